// File: rtl/demux2bit_router_pkg.sv
// Shared constants for the 2-bit demux router: default widths, port indices
// and the per-FIFO occupancy encoding.
package demux2bit_router_pkg;

  localparam int WIDTH_DEF = 2;
  localparam int CNT_W_DEF = 8;
  localparam int NUM_PORTS = 2;
  localparam int PORT_A    = 0;
  localparam int PORT_B    = 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/demux2bit_fifo2.sv
// Two-entry FIFO with a delivered-item counter; one instance per router port.
// head_reg always holds the oldest item, tail_reg the second one when FULL.
module demux2bit_fifo2
  import demux2bit_router_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  input  logic             ready,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  occ_t             state_reg, state_next;
  logic [WIDTH-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pop, push_ok;

  assign pop     = valid & ready;
  assign push_ok = push & (state_reg != FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: if (push_ok) state_next = ONE;
      ONE: begin
        if (push_ok && !pop)      state_next = FULL;
        else if (!push_ok && pop) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    valid = (state_reg != EMPTY);
    full  = (state_reg == FULL);
  end

  // No bypass: a push into EMPTY lands in head_reg and is seen next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (pop) count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      case (state_reg)
        EMPTY: if (push_ok) head_reg <= din;
        ONE: begin
          if (push_ok && pop) head_reg <= din;
          else if (push_ok)   tail_reg <= din;
        end
        FULL:    if (pop) head_reg <= tail_reg;
        default: ;
      endcase
    end
  end

  assign dout  = head_reg;
  assign count = count_reg;

endmodule

// File: rtl/demux2bit_router.sv
// Splits one 2-bit stream onto ports A/B by in_control; each port is buffered
// by its own FIFO so a stalled consumer only blocks items headed to it.
module demux2bit_router
  import demux2bit_router_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_control,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  logic [NUM_PORTS-1:0] push_vec;
  logic [NUM_PORTS-1:0] full_vec;
  logic [NUM_PORTS-1:0] valid_vec;
  logic [NUM_PORTS-1:0] ready_vec;
  logic [WIDTH-1:0]     dout_arr  [NUM_PORTS];
  logic [CNT_W-1:0]     count_arr [NUM_PORTS];

  // Depends only on in_control and occupancy, never on the consumer readies.
  assign in_ready = ~full_vec[in_control];

  assign ready_vec[PORT_A] = a_ready;
  assign ready_vec[PORT_B] = b_ready;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign push_vec[gi] = in_valid & in_ready & (int'(in_control) == gi);

      demux2bit_fifo2 #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_vec[gi]),
        .din   (in_data),
        .dout  (dout_arr[gi]),
        .valid (valid_vec[gi]),
        .ready (ready_vec[gi]),
        .full  (full_vec[gi]),
        .count (count_arr[gi])
      );
    end
  endgenerate

  assign a_data  = dout_arr[PORT_A];
  assign a_valid = valid_vec[PORT_A];
  assign a_count = count_arr[PORT_A];
  assign b_data  = dout_arr[PORT_B];
  assign b_valid = valid_vec[PORT_B];
  assign b_count = count_arr[PORT_B];

endmodule

// File: tb/tb_demux2bit_router.sv
// Self-checking bench for demux2bit_router: directed scenarios plus random
// traffic, all compared against a queue-based model of the two ports.
module tb_demux2bit_router;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] in_data = '0;
  logic       in_control = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready = 1'b0, b_ready = 1'b0;
  logic [7:0] a_count, b_count;

  int total = 0;
  int bad = 0;

  // Reference model: one queue per port plus wrapping delivery counters.
  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic [7:0] ca = '0, cb = '0;
  bit         last_acc;

  demux2bit_router dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_control (in_control),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_data     (a_data),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .b_data     (b_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .a_count    (a_count),
    .b_count    (b_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    return in_control ? (qb.size() < 2) : (qa.size() < 2);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".a_valid"}, 32'(a_valid), 32'(qa.size() > 0));
    if (qa.size() > 0) chk({tag, ".a_data"}, 32'(a_data), 32'(qa[0]));
    chk({tag, ".b_valid"}, 32'(b_valid), 32'(qb.size() > 0));
    if (qb.size() > 0) chk({tag, ".b_data"}, 32'(b_data), 32'(qb[0]));
    chk({tag, ".a_count"}, 32'(a_count), 32'(ca));
    chk({tag, ".b_count"}, 32'(b_count), 32'(cb));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(model_ready()));
  endtask

  // One clock: decide the model's accept/pops from pre-edge inputs, then apply.
  task automatic tick(input string tag);
    bit acc, pa, pb;
    logic [1:0] d;
    logic c;
    acc = in_valid && model_ready();
    pa  = a_ready && (qa.size() > 0);
    pb  = b_ready && (qb.size() > 0);
    d   = in_data;
    c   = in_control;
    @(posedge clk);
    #1;
    if (pa) begin void'(qa.pop_front()); ca = ca + 8'd1; end
    if (pb) begin void'(qb.pop_front()); cb = cb + 8'd1; end
    if (acc) begin
      if (c) qb.push_back(d);
      else   qa.push_back(d);
    end
    last_acc = acc;
    $display("[%0t] %s: acc=%0d in_ready=%0b a_v=%0b a_d=%0d a_cnt=%0d b_v=%0b b_d=%0d b_cnt=%0d",
             $time, tag, acc, in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count);
    check_all(tag);
  endtask

  task automatic drive(input bit v, input logic [1:0] d, input bit c, input bit ar, input bit br);
    in_valid   = v;
    in_data    = d;
    in_control = c;
    a_ready    = ar;
    b_ready    = br;
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset(input string tag);
    #3;
    reset = 1'b1;
    #1;
    chk({tag, ".rst_a_valid"}, 32'(a_valid), 32'd0);
    chk({tag, ".rst_b_valid"}, 32'(b_valid), 32'd0);
    chk({tag, ".rst_a_data"},  32'(a_data),  32'd0);
    chk({tag, ".rst_b_data"},  32'(b_data),  32'd0);
    chk({tag, ".rst_a_count"}, 32'(a_count), 32'd0);
    chk({tag, ".rst_b_count"}, 32'(b_count), 32'd0);
    qa.delete();
    qb.delete();
    ca = '0;
    cb = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    $display("[%0t] %s: reset released in_ready=%0b", $time, tag, in_ready);
    chk({tag, ".rel_in_ready"}, 32'(in_ready), 32'd1);
    check_all({tag, ".released"});
  endtask

  initial begin
    logic [7:0] ca0, cb0;

    @(posedge clk);
    #1;
    do_reset("init");

    // Single route to A, then deliver it.
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    tick("single.push");
    chk("single.a_valid", 32'(a_valid), 32'd1);
    chk("single.a_data",  32'(a_data),  32'h1);
    chk("single.b_valid", 32'(b_valid), 32'd0);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    tick("single.pop");
    chk("single.a_count", 32'(a_count), 32'd1);

    // Backpressure isolation: fill B while its consumer is stalled.
    drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    tick("bp.push_b0");
    drive(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    tick("bp.push_b1");
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    #1;
    chk("bp.in_ready_b_full", 32'(in_ready), 32'd0);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    chk("bp.in_ready_a_free", 32'(in_ready), 32'd1);
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    tick("bp.push_a");
    chk("bp.a_valid", 32'(a_valid), 32'd1);
    chk("bp.b_data",  32'(b_data),  32'h2);

    // Full with pop: push to B refused while its head leaves.
    drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    tick("fullpop");
    chk("fullpop.b_data",  32'(b_data),  32'h3);
    chk("fullpop.b_count", 32'(b_count), 32'd1);
    chk("fullpop.refused", 32'(last_acc), 32'd0);

    // Drain both ports, then stream 20 alternating items.
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick("drain");
    ca0 = a_count;
    cb0 = b_count;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 1'(i % 2), 1'b1, 1'b1);
      tick("stream");
      chk("stream.accepted", 32'(last_acc), 32'd1);
    end
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick("stream.drain");
    chk("stream.a_delta", 32'(8'(a_count - ca0)), 32'd10);
    chk("stream.b_delta", 32'(8'(b_count - cb0)), 32'd10);

    // Counter wrap: 256 deliveries on A.
    do_reset("wrap");
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b1, 1'b1);
      tick("wrap");
    end
    chk("wrap.a_count_255", 32'(a_count), 32'd255);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    tick("wrap.last");
    tick("wrap.idle");
    chk("wrap.a_count_0", 32'(a_count), 32'd0);
    chk("wrap.b_count",   32'(b_count), 32'd0);

    // Random traffic; a pending unaccepted offer is held stable.
    last_acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid   = ($urandom_range(0, 3) != 0);
        in_data    = 2'($urandom_range(0, 3));
        in_control = 1'($urandom_range(0, 1));
      end
      a_ready = ($urandom_range(0, 9) < 6);
      b_ready = ($urandom_range(0, 9) < 4);
      tick("rand");
    end

    // Reset in the middle of traffic discards stored items.
    drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    tick("mid.push_a");
    drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    tick("mid.push_b");
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    do_reset("mid");
    tick("mid.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
